// File: rtl/mips_mem_pkg.sv
// Shared definitions for the load/store unit: access size encodings,
// FSM state enum, word-address constant and the alignment check.
package mips_mem_pkg;

  localparam int unsigned WORD_ADDR_LSB = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

  // True when the low address bits do not match the natural alignment of the size.
  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] lo);
    return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the load/store unit: little-endian lane
// extraction with sign/zero extension for loads, and lane merge of store
// data into a read word for sub-word stores.
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  lsu_size_e   size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  input  logic [31:0] load_word_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] base_word_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign byte_sh = {lane_i, 3'b000};
  assign half_sh = {lane_i[1], 4'b0000};
  assign lane_b  = load_word_i[byte_sh +: 8];
  assign lane_h  = load_word_i[half_sh +: 16];

  // Right-justify the selected lane(s) and extend to 32 bits.
  always_comb begin
    load_data_o = '0;
    case (size_i)
      SZ_BYTE: load_data_o = unsigned_i ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: load_data_o = unsigned_i ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      SZ_WORD: load_data_o = load_word_i;
      default: load_data_o = '0;
    endcase
  end

  // Replace only the addressed lane(s) of the base word with store data.
  always_comb begin
    merged_o = base_word_i;
    case (size_i)
      SZ_BYTE: merged_o[byte_sh +: 8]  = store_data_i[7:0];
      SZ_HALF: merged_o[half_sh +: 16] = store_data_i[15:0];
      SZ_WORD: merged_o = store_data_i;
      default: merged_o = base_word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one access at a time, performs a word read,
// a word write or a read-modify-write against a word-wide data memory,
// and returns one response strobe per request.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses
// respond with an error instead of having their low address bits cleared.
module load_store_unit
  import mips_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        rdy_q;
  logic        we_q;
  lsu_size_e   size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  lsu_size_e   size_in;
  logic        accept;
  logic        req_err;
  logic [31:0] addr_fix;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign size_in = lsu_size_e'(req_size);
  assign accept  = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = (size_in == SZ_RSVD) || is_misaligned(size_in, req_addr[1:0]);
`else
  assign req_err = (size_in == SZ_RSVD);
`endif

  // Clear offending low address bits when misalignment is not trapped.
  always_comb begin
    addr_fix = req_addr;
`ifndef LSU_MISALIGN_TRAP_EN
    if (size_in == SZ_HALF) addr_fix[0] = 1'b0;
    if (size_in == SZ_WORD) addr_fix[1:0] = 2'b00;
`endif
  end

  lsu_lane_align u_align (
    .size_i       (size_q),
    .lane_i       (lane_q),
    .unsigned_i   (uns_q),
    .load_word_i  (rdata_q),
    .store_data_i (wdata_q),
    .base_word_i  (mem_rdata),
    .load_data_o  (load_data),
    .merged_o     (merged)
  );

  // State register; rdy_q holds req_ready low until the first edge out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                              state_d = RESP;
          else if (!req_we || (size_in != SZ_WORD)) state_d = READ;
          else                                      state_d = WRITE;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, read-data capture and memory address/data holding registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      lane_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        size_q  <= size_in;
        uns_q   <= req_unsigned;
        lane_q  <= addr_fix[1:0];
        wdata_q <= req_wdata;
        err_q   <= req_err;
        if (!req_err) begin
          mem_addr_q <= {addr_fix[31:WORD_ADDR_LSB], {WORD_ADDR_LSB{1'b0}}};
          if (req_we && (size_in == SZ_WORD)) mem_wdata_q <= req_wdata;
        end
      end
      if (state_q == READ) begin
        rdata_q <= mem_rdata;
        // Sub-word store: merge into the word being read so WRITE sees a stable value.
        if (we_q) mem_wdata_q <= merged;
      end
    end
  end

  // Outputs decoded from state; memory strobes are gated by reset so an
  // access interrupted by reset never pulses.
  always_comb begin
    req_ready  = rdy_q && (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_err   = (state_q == RESP) && err_q;
    resp_rdata = ((state_q == RESP) && !we_q && !err_q) ? load_data : '0;
    mem_read   = rst_n && (state_q == READ);
    mem_write  = rst_n && (state_q == WRITE);
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all other ports are listed below.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 req_valid  input  1  pipeline access request.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  encoding: 00 = byte, 01 = half, 10 = word; 11 is reserved.
REQ-008 req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion strobe.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores.
REQ-013 resp_err  output  1  misaligned or reserved-size access.
REQ-014 mem_addr  output  32  word-aligned address to data memory.
REQ-015 mem_wdata  output  32  full word to data memory.
REQ-016 mem_read  output  1  memory read enable.
REQ-017 mem_write  output  1  memory write pulse.
REQ-018 mem_rdata  input  32  combinational read data from memory.

Function
REQ-019 The FSM SHALL have the states IDLE, READ, WRITE and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle where req_valid=1 and req_ready=1, and all request fields are registered on acceptance.
REQ-021 After acceptance, a load or a sub-word store SHALL go to READ; a word store SHALL go to WRITE.
REQ-022 In READ, mem_read=1 and mem_addr={addr[31:2],2'b00} for exactly one cycle, and mem_rdata is registered at the end of that cycle.
REQ-023 From READ, a load SHALL go to RESP and a sub-word store SHALL go to WRITE.
REQ-024 In WRITE, mem_write=1 for exactly one cycle, with a stable mem_addr and mem_wdata; the next state is RESP.
REQ-025 A sub-word store SHALL write the read word with only the addressed lane(s) replaced by req_wdata[7:0] or req_wdata[15:0] (read-modify-write).
REQ-026 In RESP, resp_valid=1 for exactly one cycle; the next state is IDLE.
REQ-027 Latency from acceptance to resp_valid SHALL be:
- word load: 2 cycles;
- word store: 2 cycles;
- sub-word store: 3 cycles;
- error: 1 cycle.
REQ-028 Lane mapping SHALL be little-endian: byte lane = addr[1:0], lane 0 = bits [7:0]; a half-word uses lane addr[1]*2.
REQ-029 Load extraction SHALL right-justify the selected lane(s) and then sign- or zero-extend them to 32 bits according to the registered req_unsigned.
REQ-030 Outside READ, mem_read SHALL be 0; outside WRITE, mem_write SHALL be 0; mem_addr and mem_wdata SHALL hold their last values.
REQ-031 req_size=11 SHALL give resp_err=1 and no memory activity, regardless of configuration.
REQ-032 req_valid asserted while req_ready=0 SHALL be ignored; there is no queuing.

Reset
REQ-033 While rst_n=0 at a clock edge, the state SHALL become IDLE and every output SHALL be 0, except req_ready, which SHALL be 1 from the first cycle after rst_n rises.
REQ-034 A reset during READ or WRITE SHALL abandon the access: no mem_write pulse and no resp_valid are issued afterwards.

Configuration
REQ-035 With LSU_MISALIGN_TRAP_EN defined, a half access with addr[0]=1, or a word access with addr[1:0]≠00, SHALL go directly IDLE→RESP with resp_err=1, resp_rdata=0 and no memory activity.
REQ-036 Without LSU_MISALIGN_TRAP_EN, offending low address bits SHALL be forced to 0 (half: bit 0; word: bits [1:0]), and resp_err SHALL be 1 only for req_size=11.

Structure
REQ-037 The shared package mips_mem_pkg SHALL hold:
- the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
- the FSM state enum;
- the constant WORD_ADDR_LSB=2.
REQ-038 Lane extraction, extension and store merge SHALL live in one combinational sub-module, lsu_lane_align; the FSM and registers stay in load_store_unit.

Verification
REQ-039 Word store of 0xDEADBEEF to 0x10 → WRITE one cycle later with mem_addr=0x10, mem_wdata=0xDEADBEEF and one mem_write pulse; resp_valid 2 cycles after acceptance.
REQ-040 Memory word 0x10=0x8899AABB; lb at 0x11 → resp_rdata=0xFFFFFFAA; lbu at 0x11 → 0x000000AA; lh at 0x12 → 0xFFFF8899.
REQ-041 Memory word 0x20=0x11223344; sb of 0x55 at 0x22 → mem_read cycle, then mem_wdata=0x11553344; resp_valid 3 cycles after acceptance.
REQ-042 lw at 0x13 → with LSU_MISALIGN_TRAP_EN: resp_err=1 after 1 cycle, no mem_read; without it: mem_addr=0x10, resp_err=0.
REQ-043 rst_n=0 in the cycle the FSM is in WRITE for an sh → no mem_write pulse, no resp_valid, and req_ready=1 on the cycle after release.
REQ-044 Back-to-back requests with req_valid held high → each accepted only in IDLE; req_ready=0 throughout READ, WRITE and RESP; no request dropped or duplicated.
